// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the
// instruction-fetch stage (IF) and the data-memory stage (DM). Each access
// is sequenced IDLE -> ISSUE -> (WAIT) -> DONE. DM requests win over IF.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   if_req/if_addr     fetch request and byte address
//   if_flush           discard the result of an in-flight fetch
//   if_rdata/if_valid  fetched instruction and its one-cycle valid pulse
//   dm_req/dm_we/...   load/store request, address, store data and strobes
//   dm_rdata/dm_valid  load data and the one-cycle completion pulse
//   mem_*              shared memory port (mem_rdata valid MEM_LAT cycles
//                      after the mem_en cycle)
//   stall_if/stall_mem combinational pipeline stalls
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,

    output logic        stall_if,
    output logic        stall_mem
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flushed_q, flushed_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        dm_rdata_q, dm_rdata_d;
    logic               dm_valid_q, dm_valid_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            cnt_q      <= '0;
            flushed_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdata_q <= 32'h0;
            if_valid_q <= 1'b0;
            dm_rdata_q <= 32'h0;
            dm_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_rdata_q <= if_rdata_d;
            if_valid_q <= if_valid_d;
            dm_rdata_q <= dm_rdata_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    // Next-state and registered-output logic; the strobes and valid pulses
    // are computed one state ahead so they are high exactly in ISSUE / DONE.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        flushed_d  = flushed_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        if_valid_d = 1'b0;
        dm_rdata_d = dm_rdata_q;
        dm_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                flushed_d = 1'b0;
                if (dm_req) begin
                    owner_d  = OWN_DM;
                    we_d     = dm_we;
                    addr_d   = dm_addr;
                    wdata_d  = dm_wdata;
                    wstrb_d  = dm_wstrb;
                    mem_en_d = 1'b1;
                    mem_we_d = dm_we;
                    state_d  = S_ISSUE;
                end else if (if_req) begin
                    owner_d   = OWN_IF;
                    we_d      = 1'b0;
                    addr_d    = if_addr;
                    wstrb_d   = 4'h0;
                    mem_en_d  = 1'b1;
                    flushed_d = if_flush;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if ((owner_q == OWN_IF) && if_flush) begin
                    flushed_d = 1'b1;
                end
                if (we_q) begin
                    // Stores complete without a read phase; only DM issues them.
                    dm_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if ((owner_q == OWN_IF) && if_flush) begin
                    flushed_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = mem_rdata;
                        dm_valid_d = 1'b1;
                    end else begin
                        // A flushed fetch still updates if_rdata, only the pulse is dropped.
                        if_rdata_d = mem_rdata;
                        if_valid_d = ~(flushed_q | if_flush);
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // The valid pulse is already out; a flush here has nothing left to suppress.
                flushed_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    // Stalls drop in the valid cycle so the pipeline advances on that edge.
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT = 2): a per-cycle vector
// table plus a hand-written mid-transaction reset sequence. A small memory
// model returns f(addr) exactly MEM_LAT cycles after a read strobe.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_LAT = 2;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears only in the cycle MEM_LAT after mem_en.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h10) ? 32'h00A0_0093 : (a ^ 32'hA5A5_0000);
    endfunction

    logic        pipe_v [MEM_LAT];
    logic [31:0] pipe_a [MEM_LAT];

    initial begin
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        pipe_v[0] <= mem_en & ~mem_we;
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign mem_rdata = pipe_v[MEM_LAT-1] ? mem_f(pipe_a[MEM_LAT-1]) : 32'hBAD0_BAD0;

    typedef struct packed {
        logic        chk;
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        fl;
        logic        dmr;
        logic        we;
        logic [31:0] dma;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        en;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mws;
        logic        ifv;
        logic [31:0] ifd;
        logic        dmv;
        logic [31:0] dmd;
        logic        sif;
        logic        smem;
    } vec_t;

    vec_t vecs [$];
    int   checks;
    int   errors;

    function automatic vec_t mk(
        input logic chk, input logic r, input logic ifr, input logic [31:0] ifa,
        input logic fl, input logic dmr, input logic we, input logic [31:0] dma,
        input logic [31:0] wd, input logic [3:0] ws,
        input logic en, input logic mwe, input logic [31:0] maddr,
        input logic [31:0] mwd, input logic [3:0] mws,
        input logic ifv, input logic [31:0] ifd, input logic dmv,
        input logic [31:0] dmd, input logic sif, input logic smem);
        vec_t v;
        v.chk = chk; v.rst = r; v.ifr = ifr; v.ifa = ifa; v.fl = fl;
        v.dmr = dmr; v.we = we; v.dma = dma; v.wd = wd; v.ws = ws;
        v.en = en; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd; v.mws = mws;
        v.ifv = ifv; v.ifd = ifd; v.dmv = dmv; v.dmd = dmd;
        v.sif = sif; v.smem = smem;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] D1 = 32'hA5A5_0100;
    localparam logic [31:0] I1 = 32'hA5A5_0020;
    localparam logic [31:0] I0 = 32'h00A0_0093;
    localparam logic [31:0] I5 = 32'hA5A5_0050;
    localparam logic [31:0] I6 = 32'hA5A5_0060;
    localparam logic [31:0] I7 = 32'hA5A5_0070;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        int  n;
        bool_blk: begin end
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        if_flush = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        dm_wstrb = 4'h0;

        //           chk rst ifr ifa    fl dmr we dma     wd  ws  | en mwe maddr   mwd mws ifv ifd dmv dmd sif smem
        // Reset with both requests held, then DM load 0x100 beats fetch 0x20.
        vecs.push_back(mk(0, 1, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  0, 0, 32'h0,   0, 0, 0, 0,  0, 0,  1, 1)); // R0
        vecs.push_back(mk(1, 1, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  0, 0, 32'h0,   0, 0, 0, 0,  0, 0,  1, 1)); // R1
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  0, 0, 32'h0,   0, 0, 0, 0,  0, 0,  1, 1)); // R2 t
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  1, 0, 32'h100, 0, 0, 0, 0,  0, 0,  1, 1)); // R3 issue
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  0, 0, 32'h100, 0, 0, 0, 0,  0, 0,  1, 1));
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  0, 0, 32'h100, 0, 0, 0, 0,  0, 0,  1, 1));
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 1, 0, 32'h100, 0, 0,  0, 0, 32'h100, 0, 0, 0, 0,  1, D1, 1, 0)); // R6 dm_valid
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h100, 0, 0, 0, 0,  0, D1, 1, 0)); // R7 IF accepted
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h20,  0, 0, 0, 0,  0, D1, 1, 0)); // R8 issue
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h20,  0, 0, 0, 0,  0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h20,  0, 0, 0, 0,  0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h20, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h20,  0, 0, 1, I1, 0, D1, 0, 0)); // R11 if_valid
        // Back-to-back single fetch of 0x10.
        vecs.push_back(mk(1, 0, 1, 32'h10, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h20,  0, 0, 0, I1, 0, D1, 1, 0)); // R12 t
        vecs.push_back(mk(1, 0, 1, 32'h10, 0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h10,  0, 0, 0, I1, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h10, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h10,  0, 0, 0, I1, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h10, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h10,  0, 0, 0, I1, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h10, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h10,  0, 0, 1, I0, 0, D1, 0, 0)); // R16
        // Store 0x200.
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 1, 1, 32'h200, DB, 4'hF, 0, 0, 32'h10,  0,  0,    0, I0, 0, D1, 0, 1)); // R17 t
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 1, 1, 32'h200, DB, 4'hF, 1, 1, 32'h200, DB, 4'hF, 0, I0, 0, D1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 1, 1, 32'h200, DB, 4'hF, 0, 0, 32'h200, DB, 4'hF, 0, I0, 1, D1, 0, 0)); // R19
        // Fetch 0x50 flushed at t+2, then new fetch 0x60 accepted at t+5.
        vecs.push_back(mk(1, 0, 1, 32'h50, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h200, DB, 4'hF, 0, I0, 0, D1, 1, 0)); // R20 t
        vecs.push_back(mk(1, 0, 1, 32'h50, 0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h50,  DB, 0, 0, I0, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h50, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h50,  DB, 0, 0, I0, 0, D1, 1, 0)); // flush
        vecs.push_back(mk(1, 0, 1, 32'h50, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h50,  DB, 0, 0, I0, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h50, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h50,  DB, 0, 0, I5, 0, D1, 1, 0)); // R24 no pulse
        vecs.push_back(mk(1, 0, 1, 32'h60, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h50,  DB, 0, 0, I5, 0, D1, 1, 0)); // R25 idle
        vecs.push_back(mk(1, 0, 1, 32'h60, 0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h60,  DB, 0, 0, I5, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h60, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h60,  DB, 0, 0, I5, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h60, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h60,  DB, 0, 0, I5, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h60, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h60,  DB, 0, 1, I6, 0, D1, 0, 0)); // R29
        // Flush with nothing in flight must not affect the next fetch.
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h60,  DB, 0, 0, I6, 0, D1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,  1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h60,  DB, 0, 0, I6, 0, D1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h70, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h60,  DB, 0, 0, I6, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h70, 0, 0, 0, 32'h0,   0, 0,  1, 0, 32'h70,  DB, 0, 0, I6, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h70, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h70,  DB, 0, 0, I6, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h70, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h70,  DB, 0, 0, I6, 0, D1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h70, 0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h70,  DB, 0, 1, I7, 0, D1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 0, 0, 32'h0,   0, 0,  0, 0, 32'h70,  DB, 0, 0, I7, 0, D1, 0, 0));

        foreach (vecs[r]) begin
            next_cycle();
            rst      = vecs[r].rst;
            if_req   = vecs[r].ifr;
            if_addr  = vecs[r].ifa;
            if_flush = vecs[r].fl;
            dm_req   = vecs[r].dmr;
            dm_we    = vecs[r].we;
            dm_addr  = vecs[r].dma;
            dm_wdata = vecs[r].wd;
            dm_wstrb = vecs[r].ws;
            #4;
            if (vecs[r].chk) begin
                check("mem_en",    r, 32'(mem_en),    32'(vecs[r].en));
                check("mem_we",    r, 32'(mem_we),    32'(vecs[r].mwe));
                check("mem_addr",  r, mem_addr,       vecs[r].maddr);
                check("mem_wdata", r, mem_wdata,      vecs[r].mwd);
                check("mem_wstrb", r, 32'(mem_wstrb), 32'(vecs[r].mws));
                check("if_valid",  r, 32'(if_valid),  32'(vecs[r].ifv));
                check("if_rdata",  r, if_rdata,       vecs[r].ifd);
                check("dm_valid",  r, 32'(dm_valid),  32'(vecs[r].dmv));
                check("dm_rdata",  r, dm_rdata,       vecs[r].dmd);
                check("stall_if",  r, 32'(stall_if),  32'(vecs[r].sif));
                check("stall_mem", r, 32'(stall_mem), 32'(vecs[r].smem));
            end
        end

        // Reset during WAIT of a load: transaction abandoned, no dm_valid.
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_wdata = 32'h0; dm_wstrb = 4'h0;
        next_cycle();
        #4;
        check("rstwait_issue", -1, 32'(mem_en), 32'd1);
        next_cycle();
        rst = 1'b1; dm_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        #4;
        check("rstwait_mem_en",   -1, 32'(mem_en),    32'd0);
        check("rstwait_mem_addr", -1, mem_addr,       32'h0);
        check("rstwait_wdata",    -1, mem_wdata,      32'h0);
        check("rstwait_wstrb",    -1, 32'(mem_wstrb), 32'h0);
        check("rstwait_if_rdata", -1, if_rdata,       32'h0);
        check("rstwait_dm_rdata", -1, dm_rdata,       32'h0);
        check("rstwait_dm_valid", -1, 32'(dm_valid),  32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            #4;
            if (dm_valid || mem_en || if_valid) n++;
        end
        check("rstwait_quiet", -1, 32'(n), 32'd0);

        // New load after the abandoned one completes with normal latency.
        next_cycle();
        dm_req = 1'b1; dm_addr = 32'h100;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            #4;
            n++;
            if (dm_valid) break;
        end
        check("post_rst_latency", -1, 32'(n), 32'd4);
        check("post_rst_dm_rdata", -1, dm_rdata, D1);
        next_cycle();
        dm_req = 1'b0;
        #4;
        check("post_rst_idle", -1, 32'(dm_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
